multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Moore-style sequencing FSM that replaces the single-cycle opcode decoder for the multicycle MIPS datapath.
- Drives PC, IR, register file, ALU mux and memory enables state by state.
- Waits on a memory ready handshake and traps undefined opcodes and functs.
- Sits between the instruction register (opcode/funct), the ALU zero flag, and the shared instruction/data memory.

Parameters:
- EXC_ENABLE, 1, 1 = route undefined opcode/funct to EXCEPT; 0 = treat them as NOP and return to FETCH.
- ST_W, 4, state register width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0], valid with opcode 0
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory finished current access this cycle
- pc_write  out  1  load PC
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  load IR
- reg_write  out  1  register file write enable
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- mem2reg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2
- alu_op  out  2  00 = add (io), 01 = branch sub, 10 = R-type via funct, 11 = I-type via opcode
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
- exception  out  1  trap taken this cycle
- state  out  ST_W  current state, for debug and coverage

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EXEC=6, R_WB=7, BRANCH=8, JUMP=9, I_EXEC=10, I_WB=11, JR=12, EXCEPT=13. Codes 14 and 15 are illegal and go to FETCH on the next edge.
- Reset: while rst=1, every enable output is 0, all mux selects are 00, and state is forced to FETCH at the edge. After reset is released, fetch starts on the first clk edge.
- Outputs are combinational from state, plus mem_ready or zero where noted. Unlisted outputs are 0 or 00.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write and pc_write = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when it is 1.
- DECODE: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute). Next state by opcode:
  - lw/lbu/lhu/sw/sb/sh -> MEM_ADDR
  - 0 -> R_EXEC, except funct 8 (jr) -> JR
  - beq(4)/bne(5) -> BRANCH
  - j(2)/jal(3) -> JUMP
  - addi(8)/slti(10)/sltiu(11)/andi(12)/ori(13)/lui(15) -> I_EXEC
  - anything else -> EXCEPT
- R-type funct legal set: 0 sll, 2 srl, 8 jr, 32 add, 34 sub, 38 xor, 37 or, 39 nor, 42 slt, 43 sltu. Any other funct -> EXCEPT.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00. Next is MEM_RD for loads, MEM_WR for stores.
- MEM_RD: mem_read=1, iord=1. Hold until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, mem2reg=01, then FETCH.
- MEM_WR: mem_write=1, iord=1. Hold until mem_ready, then FETCH.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, then R_WB.
- R_WB: reg_write=1, reg_dst=01, mem2reg=00, then FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=11, then I_WB.
- I_WB: reg_write=1, reg_dst=00, mem2reg=00, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01.
  - pc_write = zero for beq, ~zero for bne.
  - Then FETCH.
- JUMP: pc_write=1, pc_source=10.
  - jal additionally: reg_write=1, reg_dst=10, mem2reg=10 (PC already holds PC+4).
  - Then FETCH.
- JR: alu_src_a=1, alu_op=10, pc_write=1, pc_source=00, then FETCH.
- EXCEPT: exception=1, pc_write=1, pc_source=11, then FETCH. With EXC_ENABLE=0 the state is still entered, but exception=0 and pc_write=0.
- mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- rst asserted mid-instruction aborts it: no write enable is asserted during the reset cycle.
- Each instruction is exactly one pass of the FSM. Minimum latencies with mem_ready=1:
  - j/jal/beq/bne/jr: 3 cycles
  - R-type and I-type: 4 cycles
  - sw: 4 cycles
  - lw: 5 cycles

Decomposition:
- Shared package mips_pkg holds:
  - opcode and funct constants
  - state localparams
  - ALUop codes (00/01/10/11)
  - reg_dst, mem2reg, alu_src_b and pc_source select codes
- One sub-module, mc_opcode_class: combinational classification of opcode+funct into {LOAD, STORE, RTYPE, JR, BRANCH, JUMP, ITYPE, ILLEGAL}, used by the DECODE transition logic.

Test Plan:
- Reset then add (op 0, funct 32) with mem_ready=1: state sequence 0,1,6,7,0; reg_write=1 and reg_dst=01 only in state 7.
- lw (op 35), mem_ready held low 3 cycles in MEM_RD: state stays 3 for 3 cycles; exactly one reg_write pulse with mem2reg=01; lw takes 8 cycles total.
- beq with zero=1 then bne with zero=1: pc_write=1 in BRANCH for beq, 0 for bne; pc_source=01 in both.
- jal (op 3): JUMP asserts pc_write=1, pc_source=10, reg_write=1, reg_dst=10, mem2reg=10; 3 cycles total.
- Illegal opcode 63 and illegal funct 1: DECODE goes to EXCEPT, which asserts exception=1, pc_write=1, pc_source=11, then FETCH. Repeat with EXC_ENABLE=0: exception=0 and pc_write=0.
- rst pulsed in MEM_WR with mem_ready=1: mem_write=0 during the reset cycle; state=0 after the edge; all enables 0 while rst is high.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path:
// opcode/funct values, FSM states and datapath mux select codes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_BNE   = 6'd5;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_SLTIU = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LUI   = 6'd15;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_LBU   = 6'd36;
    localparam logic [5:0] OP_LHU   = 6'd37;
    localparam logic [5:0] OP_SB    = 6'd40;
    localparam logic [5:0] OP_SH    = 6'd41;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [5:0] FN_SLL  = 6'd0;
    localparam logic [5:0] FN_SRL  = 6'd2;
    localparam logic [5:0] FN_JR   = 6'd8;
    localparam logic [5:0] FN_ADD  = 6'd32;
    localparam logic [5:0] FN_SUB  = 6'd34;
    localparam logic [5:0] FN_OR   = 6'd37;
    localparam logic [5:0] FN_XOR  = 6'd38;
    localparam logic [5:0] FN_NOR  = 6'd39;
    localparam logic [5:0] FN_SLT  = 6'd42;
    localparam logic [5:0] FN_SLTU = 6'd43;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11,
        S_JR       = 4'd12,
        S_EXCEPT   = 4'd13
    } state_t;

    typedef enum logic [2:0] {
        CL_LOAD,
        CL_STORE,
        CL_RTYPE,
        CL_JR,
        CL_BRANCH,
        CL_JUMP,
        CL_ITYPE,
        CL_ILLEGAL
    } opclass_t;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;
    localparam logic [1:0] ALU_IOP   = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU  = 2'b00;
    localparam logic [1:0] PCS_OUT  = 2'b01;
    localparam logic [1:0] PCS_JUMP = 2'b10;
    localparam logic [1:0] PCS_EXC  = 2'b11;

endpackage

// File: rtl/mc_opcode_class.sv
// Classifies the IR opcode/funct pair into the instruction
// class that picks the FSM path out of DECODE.
module mc_opcode_class
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output opclass_t   o_class
);

    opclass_t w_rclass;

    always_comb begin
        w_rclass = CL_ILLEGAL;
        case (i_funct)
            FN_JR:   w_rclass = CL_JR;
            FN_SLL, FN_SRL, FN_ADD, FN_SUB, FN_OR,
            FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                     w_rclass = CL_RTYPE;
            default: w_rclass = CL_ILLEGAL;
        endcase
    end

    always_comb begin
        o_class = CL_ILLEGAL;
        case (i_opcode)
            OP_RTYPE:                o_class = w_rclass;
            OP_LW, OP_LBU, OP_LHU:   o_class = CL_LOAD;
            OP_SW, OP_SB, OP_SH:     o_class = CL_STORE;
            OP_BEQ, OP_BNE:          o_class = CL_BRANCH;
            OP_J, OP_JAL:            o_class = CL_JUMP;
            OP_ADDI, OP_SLTI, OP_SLTIU,
            OP_ANDI, OP_ORI, OP_LUI: o_class = CL_ITYPE;
            default:                 o_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multicycle MIPS datapath: one pass
// per instruction, memory-ready handshake, trap on undefined encodings.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int EXC_ENABLE = 1,
    parameter int ST_W       = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      opcode,
    input  logic [5:0]      funct,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            pc_write,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            reg_write,
    output logic [1:0]      reg_dst,
    output logic [1:0]      mem2reg,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [1:0]      alu_op,
    output logic [1:0]      pc_source,
    output logic            exception,
    output logic [ST_W-1:0] state
);

    localparam logic EXC_ON = (EXC_ENABLE != 0);

    state_t   r_state;
    state_t   w_next;
    opclass_t w_class;

    mc_opcode_class u_class (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_class  (w_class)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FETCH;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:    w_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (w_class)
                    CL_LOAD, CL_STORE: w_next = S_MEM_ADDR;
                    CL_RTYPE:          w_next = S_R_EXEC;
                    CL_JR:             w_next = S_JR;
                    CL_BRANCH:         w_next = S_BRANCH;
                    CL_JUMP:           w_next = S_JUMP;
                    CL_ITYPE:          w_next = S_I_EXEC;
                    default:           w_next = S_EXCEPT;
                endcase
            end
            S_MEM_ADDR: w_next = (w_class == CL_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   w_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   w_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   w_next = S_R_WB;
            S_I_EXEC:   w_next = S_I_WB;
            default:    w_next = S_FETCH;
        endcase
    end

    // Reset overrides every state so an aborted instruction writes nothing.
    always_comb begin
        pc_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        reg_dst   = RD_RT;
        mem2reg   = M2R_ALU;
        alu_src_a = 1'b0;
        alu_src_b = SRCB_RT;
        alu_op    = ALU_ADD;
        pc_source = PCS_ALU;
        exception = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = SRCB_IMMSH;
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    iord     = 1'b1;
                end
                S_MEM_WB: begin
                    reg_write = 1'b1;
                    mem2reg   = M2R_MDR;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = RD_RD;
                end
                S_I_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                    alu_op    = ALU_IOP;
                end
                S_I_WB: reg_write = 1'b1;
                S_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_SUB;
                    pc_source = PCS_OUT;
                    pc_write  = (opcode == OP_BNE) ? ~zero : zero;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = PCS_JUMP;
                    if (opcode == OP_JAL) begin
                        reg_write = 1'b1;
                        reg_dst   = RD_RA;
                        mem2reg   = M2R_PC;
                    end
                end
                S_JR: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALU_FUNCT;
                    pc_write  = 1'b1;
                end
                S_EXCEPT: begin
                    exception = EXC_ON;
                    pc_write  = EXC_ON;
                    pc_source = PCS_EXC;
                end
                default: ;
            endcase
        end
    end

    assign state = ST_W'(r_state);

endmodule
